// File: rtl/booth_pkg.sv
// booth_pkg: shared state encoding, Booth digit encodings and partial-product width for the radix-4 multiplier.
package booth_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    typedef enum logic [2:0] {DIG_ZERO, DIG_P1, DIG_P2, DIG_M1, DIG_M2} digit_t;

    // Radix-4 Booth recoding of one overlapping 3-bit multiplier group.
    function automatic digit_t booth_decode(input logic [2:0] y);
        return (y == 3'b001 || y == 3'b010) ? DIG_P1 :
               (y == 3'b011)                ? DIG_P2 :
               (y == 3'b100)                ? DIG_M2 :
               (y == 3'b101 || y == 3'b110) ? DIG_M1 : DIG_ZERO;
    endfunction

    // Two guard bits cover +/-2A, including -2 * (-2^(N-1)).
    function automatic int pp_width(input int n);
        return n + 2;
    endfunction

endpackage

// File: rtl/booth_pp_gen.sv
// booth_pp_gen: combinational radix-4 Booth partial product.
//   a  : signed multiplicand (N bits)
//   y  : Booth group {b[2i+1], b[2i], b[2i-1]}
//   pp : signed partial product in {0, +A, +2A, -A, -2A} (N+2 bits)
module booth_pp_gen
    import booth_pkg::*;
#(
    parameter int N = 8
) (
    input  logic signed [N-1:0]           a,
    input  logic        [2:0]             y,
    output logic signed [pp_width(N)-1:0] pp
);

    logic signed [N+1:0] a1;
    logic signed [N+1:0] a2;
    digit_t              d;

    assign a1 = {{2{a[N-1]}}, a};
    assign a2 = a1 <<< 1;

    always_comb begin
        d  = booth_decode(y);
        pp = (d == DIG_P1) ? a1 :
             (d == DIG_P2) ? a2 :
             (d == DIG_M1) ? -a1 :
             (d == DIG_M2) ? -a2 : '0;
    end

endmodule

// File: rtl/booth_radix4_seq_mul.sv
// booth_radix4_seq_mul: sequential radix-4 Booth signed multiplier, one Booth group per cycle.
//   clk, rst_n          : clock, synchronous active-low reset
//   in_valid/in_ready   : operand handshake (ready only in IDLE)
//   a, b                : signed multiplicand / multiplier (N bits)
//   out_valid/out_ready : product handshake (valid only in DONE)
//   product             : signed a*b (2N bits), held after the take
//   busy                : high in RUN or DONE
module booth_radix4_seq_mul
    import booth_pkg::*;
#(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] product,
    output logic           busy
);

    localparam int             IW   = $clog2(N / 2);
    localparam int             PW   = pp_width(N);
    localparam logic [IW-1:0]  LAST = IW'(N / 2 - 1);

    state_t               state;
    state_t               state_nx;
    logic signed [N-1:0]  ra;
    logic        [N-1:0]  rb;
    logic        [2*N-1:0] acc;
    logic        [IW-1:0] idx;
    logic        [N:0]    bx;
    logic        [2:0]    y;
    logic signed [PW-1:0] pp;
    logic        [2*N-1:0] pp_ext;

    // b[-1] = 0 is the appended LSB, so group idx starts at bit 2*idx.
    assign bx     = {rb, 1'b0};
    assign y      = bx[2*idx +: 3];
    assign pp_ext = {{(2*N-PW){pp[PW-1]}}, pp};
    assign product = acc;

    booth_pp_gen #(.N(N)) u_pp (
        .a  (ra),
        .y  (y),
        .pp (pp)
    );

    always_comb begin
        state_nx  = (state == IDLE) ? (in_valid ? RUN : IDLE) :
                    (state == RUN)  ? ((idx == LAST) ? DONE : RUN) :
                                      (out_ready ? IDLE : DONE);
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        busy      = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            acc   <= '0;
            idx   <= '0;
            ra    <= '0;
            rb    <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && in_valid) begin
                ra  <= a;
                rb  <= b;
                acc <= '0;
                idx <= '0;
            end else if (state == RUN) begin
                acc <= acc + (pp_ext << (2 * idx));
                idx <= idx + 1'b1;
            end
        end
    end

endmodule
